// File: rtl/ro_monitor_pkg.sv
// Shared types and default limits for the ring-oscillator frequency monitor.
// The clock-select logic at the top level reuses these defaults.
package ro_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_EVAL  = 2'd2
  } state_e;

  localparam int DEF_WINDOW       = 1024;
  localparam int DEF_CNT_W        = 16;
  localparam int DEF_MIN_EDGES    = 100;
  localparam int DEF_MAX_EDGES    = 400;
  localparam int DEF_FAIL_CONFIRM = 2;

endpackage

// File: rtl/ro_edge_counter.sv
// Rising-edge detector plus saturating edge counter with synchronous clear.
// The detector register always runs, so no false edge appears when counting starts.
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt_next_o
);

  logic             ro_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign rise = ro_i & ~ro_q;

  // The counter pins at all-ones instead of wrapping back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (rise && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ro_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      ro_q  <= ro_i;
      cnt_q <= cnt_d;
    end
  end

  // The next value already includes an edge seen on the final gate cycle.
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/ro_frequency_monitor.sv
// Counts ring-oscillator rising edges over a fixed gate window and raises a
// debounced fail flag when the count stays outside the allowed range.
module ro_frequency_monitor
  import ro_monitor_pkg::*;
#(
  parameter int WINDOW       = DEF_WINDOW,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int MIN_EDGES    = DEF_MIN_EDGES,
  parameter int MAX_EDGES    = DEF_MAX_EDGES,
  parameter int FAIL_CONFIRM = DEF_FAIL_CONFIRM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             noise_less_ro,
  input  logic             enable,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             too_slow,
  output logic             too_fast,
  output logic             fail
);

  localparam int WIN_W = $clog2(WINDOW);
  localparam int SW    = $clog2(FAIL_CONFIRM + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [SW:0]      CONFIRM  = (SW + 1)'(FAIL_CONFIRM);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_count_q, edge_count_d;
  logic             count_valid_q, count_valid_d;
  logic             too_slow_q, too_slow_d;
  logic             too_fast_q, too_fast_d;
  logic             fail_q, fail_d;
  logic [SW-1:0]    bad_q, bad_d;
  logic [SW-1:0]    good_q, good_d;

  logic [CNT_W-1:0] final_cnt;
  logic             slow, fast;
  logic [SW:0]      bad_inc, good_inc;

  // Anything outside COUNT clears the counter, so EVAL-cycle edges never count.
  ro_edge_counter #(
    .CNT_W(CNT_W)
  ) u_edge_counter (
    .clk       (clk),
    .rst       (rst),
    .ro_i      (noise_less_ro),
    .clear_i   (state_q != ST_COUNT),
    .cnt_next_o(final_cnt)
  );

  assign slow     = final_cnt < CNT_W'(MIN_EDGES);
  assign fast     = final_cnt > CNT_W'(MAX_EDGES);
  assign bad_inc  = {1'b0, bad_q} + (SW + 1)'(1);
  assign good_inc = {1'b0, good_q} + (SW + 1)'(1);

  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    edge_count_d  = edge_count_q;
    count_valid_d = 1'b0;
    too_slow_d    = too_slow_q;
    too_fast_d    = too_fast_q;
    fail_d        = fail_q;
    bad_d         = bad_q;
    good_d        = good_q;

    case (state_q)
      ST_IDLE: begin
        win_d = '0;
        if (enable) state_d = ST_COUNT;
      end
      ST_COUNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
          win_d   = '0;
        end else if (win_q == WIN_LAST) begin
          state_d       = ST_EVAL;
          win_d         = '0;
          edge_count_d  = final_cnt;
          count_valid_d = 1'b1;
          too_slow_d    = slow;
          too_fast_d    = fast;
          // Streaks saturate at the confirm depth; fail only moves once a streak completes.
          if (slow || fast) begin
            good_d = '0;
            if (bad_inc >= CONFIRM) begin
              bad_d  = CONFIRM[SW-1:0];
              fail_d = 1'b1;
            end else begin
              bad_d = bad_inc[SW-1:0];
            end
          end else begin
            bad_d = '0;
            if (good_inc >= CONFIRM) begin
              good_d = CONFIRM[SW-1:0];
              fail_d = 1'b0;
            end else begin
              good_d = good_inc[SW-1:0];
            end
          end
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end
      ST_EVAL: begin
        win_d   = '0;
        state_d = enable ? ST_COUNT : ST_IDLE;
      end
      default: begin
        win_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      win_q         <= '0;
      edge_count_q  <= '0;
      count_valid_q <= 1'b0;
      too_slow_q    <= 1'b0;
      too_fast_q    <= 1'b0;
      fail_q        <= 1'b0;
      bad_q         <= '0;
      good_q        <= '0;
    end else begin
      state_q       <= state_d;
      win_q         <= win_d;
      edge_count_q  <= edge_count_d;
      count_valid_q <= count_valid_d;
      too_slow_q    <= too_slow_d;
      too_fast_q    <= too_fast_d;
      fail_q        <= fail_d;
      bad_q         <= bad_d;
      good_q        <= good_d;
    end
  end

  assign edge_count  = edge_count_q;
  assign count_valid = count_valid_q;
  assign too_slow    = too_slow_q;
  assign too_fast    = too_fast_q;
  assign fail        = fail_q;

endmodule

// File: tb/tb_ro_frequency_monitor.sv
// Directed bench for ro_frequency_monitor: a 16-cycle window, range 3..6, and a
// second 3-bit-counter instance sharing the same stimulus to show saturation.
module tb_ro_frequency_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       noise_less_ro;
  logic       enable;
  logic [7:0] edge_count;
  logic       count_valid, too_slow, too_fast, fail;
  logic [2:0] edgeCount3;
  logic       countValid3, tooSlow3, tooFast3, fail3;

  int checkCount = 0;
  int passCount  = 0;
  int roMode     = 4;
  int phase      = 0;
  int latency;
  int seenValid;

  always #5 clk = ~clk;

  ro_frequency_monitor #(
    .WINDOW(16), .CNT_W(8), .MIN_EDGES(3), .MAX_EDGES(6), .FAIL_CONFIRM(2)
  ) dut (
    .clk(clk), .rst(rst), .noise_less_ro(noise_less_ro), .enable(enable),
    .edge_count(edge_count), .count_valid(count_valid), .too_slow(too_slow),
    .too_fast(too_fast), .fail(fail)
  );

  ro_frequency_monitor #(
    .WINDOW(16), .CNT_W(3), .MIN_EDGES(3), .MAX_EDGES(6), .FAIL_CONFIRM(2)
  ) dutNarrow (
    .clk(clk), .rst(rst), .noise_less_ro(noise_less_ro), .enable(enable),
    .edge_count(edgeCount3), .count_valid(countValid3), .too_slow(tooSlow3),
    .too_fast(tooFast3), .fail(fail3)
  );

  // Mode 0 is stuck low, 2 and 4 are the oscillator period; every pattern starts low.
  function automatic logic roBit(input int mode, input int ph);
    case (mode)
      2:       return ph[0];
      4:       return ph[1];
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
  endtask

  // Each call advances one clock: wait for the falling edge, then drive the next RO level.
  task automatic applyStimulus();
    @(negedge clk);
    noise_less_ro = roBit(roMode, phase);
    phase++;
  endtask

  task automatic setMode(input int mode);
    roMode        = mode;
    noise_less_ro = roBit(mode, 0);
    phase         = 1;
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    do begin
      applyStimulus();
      cycles++;
    end while (!count_valid && cycles < 40);
  endtask

  task automatic checkWindow(input string tag, input int expCount, input int expSlow,
                             input int expFast, input int expFail);
    checkOutput({tag, " valid"}, int'(count_valid), 1);
    checkOutput({tag, " edge_count"}, int'(edge_count), expCount);
    checkOutput({tag, " too_slow"}, int'(too_slow), expSlow);
    checkOutput({tag, " too_fast"}, int'(too_fast), expFast);
    checkOutput({tag, " fail"}, int'(fail), expFail);
  endtask

  initial begin
    rst           = 1'b0;
    enable        = 1'b1;
    noise_less_ro = 1'b0;

    repeat (5) applyStimulus();
    checkOutput("reset edge_count", int'(edge_count), 0);
    checkOutput("reset count_valid", int'(count_valid), 0);
    checkOutput("reset too_slow", int'(too_slow), 0);
    checkOutput("reset too_fast", int'(too_fast), 0);
    checkOutput("reset fail", int'(fail), 0);
    checkOutput("reset narrow edge_count", int'(edgeCount3), 0);

    rst = 1'b1;
    waitValid(latency);
    checkOutput("first window latency", latency, 17);
    checkWindow("p4 w1", 4, 0, 0, 0);
    applyStimulus();
    checkOutput("count_valid pulse", int'(count_valid), 0);
    waitValid(latency);
    checkOutput("p4 w2 latency", latency, 16);
    checkWindow("p4 w2", 4, 0, 0, 0);
    waitValid(latency);
    checkOutput("p4 w3 latency", latency, 17);
    checkWindow("p4 w3", 4, 0, 0, 0);

    setMode(0);
    waitValid(latency);
    checkOutput("stuck w1 latency", latency, 17);
    checkWindow("stuck w1", 0, 1, 0, 0);
    waitValid(latency);
    checkWindow("stuck w2", 0, 1, 0, 1);
    setMode(4);
    waitValid(latency);
    checkWindow("restore w1", 4, 0, 0, 1);
    waitValid(latency);
    checkWindow("restore w2", 4, 0, 0, 0);

    setMode(2);
    waitValid(latency);
    checkWindow("p2 w1", 8, 0, 1, 0);
    checkOutput("narrow saturate w1", int'(edgeCount3), 7);
    checkOutput("narrow too_fast w1", int'(tooFast3), 1);
    waitValid(latency);
    checkWindow("p2 w2", 8, 0, 1, 1);
    checkOutput("narrow saturate w2", int'(edgeCount3), 7);
    checkOutput("narrow valid w2", int'(countValid3), 1);
    checkOutput("narrow too_slow w2", int'(tooSlow3), 0);
    checkOutput("narrow fail w2", int'(fail3), 1);

    // Good, bad, good: neither streak completes, so fail must hold at 1.
    for (int i = 0; i < 3; i++) begin
      setMode((i % 2 == 0) ? 4 : 2);
      waitValid(latency);
      checkWindow($sformatf("alt w%0d", i), (i % 2 == 0) ? 4 : 8, 0, (i % 2 == 0) ? 0 : 1, 1);
    end

    repeat (8) applyStimulus();
    enable    = 1'b0;
    seenValid = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus();
      if (count_valid) seenValid++;
    end
    checkOutput("abort no valid", seenValid, 0);
    checkOutput("abort edge_count hold", int'(edge_count), 4);
    checkOutput("abort too_fast hold", int'(too_fast), 0);
    checkOutput("abort fail hold", int'(fail), 1);

    // The good streak from before the abort survives, so this window clears fail.
    enable = 1'b1;
    waitValid(latency);
    checkOutput("reenable latency", latency, 17);
    checkWindow("reenable w1", 4, 0, 0, 0);

    repeat (5) applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("midreset edge_count", int'(edge_count), 0);
    checkOutput("midreset count_valid", int'(count_valid), 0);
    checkOutput("midreset fail", int'(fail), 0);
    checkOutput("midreset narrow edge_count", int'(edgeCount3), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
